// File: rtl/trdemu_pkg.sv
// Shared definitions for the TR-DOS/VG93 trap capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the NMI sequencer state encoding, the capture-entry field widths and
// the #BE port number that the z80 glue decodes into clr_nmi.
// Optional: TRDEMU_TRAP_TSTAMP_EN adds an 8-bit timestamp field to each entry.
package trdemu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_NMI = 2'd2,
      SERVICE  = 2'd3
   } trap_st_t;

   localparam int A_W  = 2;
   localparam int D_W  = 8;
   localparam int TS_W = 8;

   // out (#BE),a from the handler is decoded upstream into clr_nmi.
   localparam logic [7:0] CLR_NMI_PORT = 8'hBE;

   typedef struct packed {
      logic [A_W-1:0]  a;
      logic            wr;
      logic [D_W-1:0]  d;
`ifdef TRDEMU_TRAP_TSTAMP_EN
      logic [TS_W-1:0] ts;
`endif
   } cap_ent_t;

endpackage

// File: rtl/trdemu_trap_if.sv
// Trap/capture signal bundle between the z80 glue, the NMI logic and trdemu_trap.
// Latency: n/a (wires only).
// Backpressure: none; pop is the only flow control (handler-driven).
//
// master: trap source / handler side (drives trap_*, in_nmi, clr_nmi, pop).
// slave : trdemu_trap (drives nmi_req and the cap_* head view).
// Optional: TRDEMU_TRAP_TSTAMP_EN adds cap_ts.
interface trdemu_trap_if
   import trdemu_pkg::*;
#(
   parameter int DEPTH = 4
);
   logic                   trap_stb;
   logic [A_W-1:0]         trap_a;
   logic                   trap_wr;
   logic [D_W-1:0]         trap_d;
   logic                   in_nmi;
   logic                   clr_nmi;
   logic                   pop;
   logic                   nmi_req;
   logic                   cap_valid;
   logic [A_W-1:0]         cap_a;
   logic                   cap_wr;
   logic [D_W-1:0]         cap_d;
   logic [$clog2(DEPTH):0] cap_level;
   logic                   cap_ovf;
`ifdef TRDEMU_TRAP_TSTAMP_EN
   logic [TS_W-1:0]        cap_ts;
`endif

   modport master (
      output trap_stb, trap_a, trap_wr, trap_d, in_nmi, clr_nmi, pop,
`ifdef TRDEMU_TRAP_TSTAMP_EN
      input  cap_ts,
`endif
      input  nmi_req, cap_valid, cap_a, cap_wr, cap_d, cap_level, cap_ovf
   );

   modport slave (
      input  trap_stb, trap_a, trap_wr, trap_d, in_nmi, clr_nmi, pop,
`ifdef TRDEMU_TRAP_TSTAMP_EN
      output cap_ts,
`endif
      output nmi_req, cap_valid, cap_a, cap_wr, cap_d, cap_level, cap_ovf
   );

endinterface

// File: rtl/trdemu_fifo.sv
// Small synchronous FIFO with level count, used to hold trapped VG accesses.
// Latency: a push is visible on head_dat/level the cycle after it is accepted.
// Backpressure: none upstream; a push while full (and not popping) is dropped and flagged on drop.
//
// Ports: fclk, rst_n; push/push_dat write side; pop read side (ignored when empty);
// head_dat (zero while empty), level, empty, drop (one-cycle overrun indication).
module trdemu_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 11
) (
   input  logic                   fclk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop,
   output logic [W-1:0]           head_dat,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees a slot, so a push at full is still taken.
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && full && !pop_ok;

   always_ff @(posedge fclk) begin
      if (push_ok)
         mem[wr_ptr] <= push_dat;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok)
            level <= level + LW'(1);
         else if (pop_ok && !push_ok)
            level <= level - LW'(1);
      end
   end

   // Storage is not reset; masking keeps the head view at zero while empty.
   assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/trdemu_trap.sv
// Captures trapped VG93 port accesses into a FIFO and sequences the NMI that enters the emulator handler.
// Latency: captured entry visible on cap_* one cycle after trap_stb; nmi_req rises one cycle later.
// Backpressure: none on traps; overrun drops the entry and sets sticky cap_ovf (cleared by clr_nmi).
//
// Ports: fclk, rst_n (async, active low); bus = trdemu_trap_if.slave
//   (trap_stb/trap_a/trap_wr/trap_d in, in_nmi/clr_nmi/pop in, nmi_req and cap_* out).
// Optional: TRDEMU_TRAP_TSTAMP_EN stores an fclk/256 tick count per entry, shown on cap_ts.
module trdemu_trap
   import trdemu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int NMI_LEN = 8,
   parameter int TMO     = 255
) (
   input logic          fclk,
   input logic          rst_n,
   trdemu_trap_if.slave bus
);
   localparam int CNT_MAX = (TMO > NMI_LEN - 1) ? TMO : NMI_LEN - 1;
   localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   cap_ent_t      ent_in;
   cap_ent_t      ent_head;
   logic          fifo_empty;
   logic          fifo_drop;
   logic          cap_valid;
   trap_st_t      state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          nmi_req_q;
   logic          ovf_q;

`ifdef TRDEMU_TRAP_TSTAMP_EN
   logic [7:0] pre_cnt;
   logic [7:0] ts_cnt;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         ts_cnt  <= '0;
      end else begin
         pre_cnt <= pre_cnt + 8'd1;
         if (pre_cnt == 8'hFF)
            ts_cnt <= ts_cnt + 8'd1;
      end
   end
`endif

   always_comb begin
      ent_in    = '0;
      ent_in.a  = bus.trap_a;
      ent_in.wr = bus.trap_wr;
      ent_in.d  = bus.trap_d;
`ifdef TRDEMU_TRAP_TSTAMP_EN
      ent_in.ts = ts_cnt;
`endif
   end

   trdemu_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cap_ent_t))
   ) u_fifo (
      .fclk     (fclk),
      .rst_n    (rst_n),
      .push     (bus.trap_stb),
      .push_dat (ent_in),
      .pop      (bus.pop),
      .head_dat (ent_head),
      .level    (bus.cap_level),
      .empty    (fifo_empty),
      .drop     (fifo_drop)
   );

   assign cap_valid     = !fifo_empty;
   assign bus.cap_valid = cap_valid;
   assign bus.cap_a     = ent_head.a;
   assign bus.cap_wr    = ent_head.wr;
   assign bus.cap_d     = ent_head.d;
`ifdef TRDEMU_TRAP_TSTAMP_EN
   assign bus.cap_ts    = ent_head.ts;
`endif

   // Sticky overrun: a drop in the same cycle as clr_nmi keeps the flag set.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (fifo_drop)
         ovf_q <= 1'b1;
      else if (bus.clr_nmi)
         ovf_q <= 1'b0;
   end
   assign bus.cap_ovf = ovf_q;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         nmi_req_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         nmi_req_q <= (state_nxt == REQ);
      end
   end
   assign bus.nmi_req = nmi_req_q;

   // cnt counts down the current REQ pulse or WAIT_NMI timeout; the expiring
   // cycle is the one where cnt is already zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (cap_valid && !bus.in_nmi) begin
               state_nxt = REQ;
               cnt_nxt   = CW'(NMI_LEN - 1);
            end
         end
         REQ: begin
            if (bus.in_nmi) begin
               state_nxt = SERVICE;
            end else if (cnt == '0) begin
               state_nxt = WAIT_NMI;
               cnt_nxt   = CW'(TMO);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         WAIT_NMI: begin
            if (bus.in_nmi) begin
               state_nxt = SERVICE;
            end else if (cnt == '0) begin
               state_nxt = REQ;
               cnt_nxt   = CW'(NMI_LEN - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         SERVICE: begin
            if (bus.clr_nmi && bus.in_nmi)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_trdemu_trap.sv
// Directed bench for trdemu_trap: reset, capture, overrun, push+pop, NMI timeout retry, requeue.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_trdemu_trap;
   import trdemu_pkg::*;

   localparam int DEPTH = 4;

   logic fclk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic [10:0] q[$];
   logic [10:0] ent;
   int   n;
   logic seen;
`ifdef TRDEMU_TRAP_TSTAMP_EN
   logic [7:0] ts1;
`endif

   always #5 fclk = ~fclk;

   trdemu_trap_if #(.DEPTH(DEPTH)) bus ();

   trdemu_trap #(.DEPTH(DEPTH), .NMI_LEN(8), .TMO(255)) dut (
      .fclk  (fclk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare head against scoreboard front, then pop it.
   task automatic pop_chk(input string tag);
      if (q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(bus.cap_valid), 32'd0);
      end else begin
         ent = q.pop_front();
         chk(tag, 32'({bus.cap_valid, bus.cap_a, bus.cap_wr, bus.cap_d}), 32'({1'b1, ent}));
      end
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
   endtask

   task automatic trap(input logic [1:0] a, input logic wr, input logic [7:0] d);
      bus.trap_stb = 1'b1;
      bus.trap_a   = a;
      bus.trap_wr  = wr;
      bus.trap_d   = d;
      if (q.size() < DEPTH) q.push_back({a, wr, d});
      tick();
      bus.trap_stb = 1'b0;
   endtask

   task automatic wait_rise(input string tag);
      n = 0;
      while (!bus.nmi_req && n < 400) begin tick(); n++; end
      chk(tag, 32'(bus.nmi_req), 32'd1);
   endtask

   task automatic hi_width(output int w);
      w = 0;
      while (bus.nmi_req && w < 400) begin tick(); w++; end
   endtask

   task automatic lo_gap(output int w);
      w = 0;
      while (!bus.nmi_req && w < 400) begin tick(); w++; end
   endtask

   task automatic clr_pulse();
      bus.clr_nmi = 1'b1;
      tick();
      bus.clr_nmi = 1'b0;
   endtask

   initial begin
      bus.trap_stb = 0; bus.trap_a = 0; bus.trap_wr = 0; bus.trap_d = 0;
      bus.in_nmi = 0; bus.clr_nmi = 0; bus.pop = 0;

      // 1 reset: strobe during reset must not be captured
      tick();
      bus.trap_stb = 1'b1; bus.trap_d = 8'h5A;
      tick();
      bus.trap_stb = 1'b0;
      chk("rst_outs", 32'({bus.nmi_req, bus.cap_valid, bus.cap_a, bus.cap_wr, bus.cap_d, bus.cap_ovf}), 32'd0);
      chk("rst_level", 32'(bus.cap_level), 32'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); seen |= bus.nmi_req | bus.cap_valid; end
      chk("rst_quiet", 32'(seen), 32'd0);

      // 2 single write trap
      trap(2'd3, 1'b1, 8'hA5);
      chk("t2_valid", 32'(bus.cap_valid), 32'd1);
      chk("t2_data", 32'(bus.cap_d), 32'hA5);
      wait_rise("t2_rise");
      hi_width(n);
      chk("t2_width", 32'(n), 32'd8);
      bus.in_nmi = 1'b1;
      tick();
      pop_chk("t2_head");
      clr_pulse();
      chk("t2_idle", 32'(dut.state), 32'(IDLE));
      chk("t2_empty", 32'(bus.cap_valid), 32'd0);

      // 3 overrun (in_nmi held so no request fires); clr_nmi on the drop cycle loses
      for (int i = 0; i < 5; i++) begin
         if (i == 4) bus.clr_nmi = 1'b1;
         trap(2'(i), i[0], 8'(8'h10 + i));
         bus.clr_nmi = 1'b0;
      end
      chk("t3_level", 32'(bus.cap_level), 32'd4);
      chk("t3_ovf", 32'(bus.cap_ovf), 32'd1);
      chk("t3_head", 32'({bus.cap_a, bus.cap_wr, bus.cap_d}), 32'(q[0]));
      for (int i = 0; i < 4; i++) pop_chk("t3_pop");
      chk("t3_level0", 32'(bus.cap_level), 32'd0);
      clr_pulse();
      chk("t3_ovf_clr", 32'(bus.cap_ovf), 32'd0);

      // 4 push+pop same cycle at level 2, then at level 0
      trap(2'd1, 1'b0, 8'hC1);
      trap(2'd2, 1'b1, 8'hC2);
      chk("t4_lvl2", 32'(bus.cap_level), 32'd2);
      ent = q.pop_front();
      chk("t4_head", 32'({bus.cap_a, bus.cap_wr, bus.cap_d}), 32'(ent));
      bus.pop = 1'b1;
      trap(2'd3, 1'b0, 8'hC3);
      bus.pop = 1'b0;
      chk("t4_lvl_same", 32'(bus.cap_level), 32'(q.size()));
      pop_chk("t4_ord1");
      pop_chk("t4_ord2");
      bus.pop = 1'b1;
      trap(2'd0, 1'b1, 8'hD0);
      bus.pop = 1'b0;
      chk("t4_lvl1", 32'(bus.cap_level), 32'd1);
      pop_chk("t4_d0");
      chk("t4_lvl0", 32'(bus.cap_level), 32'd0);
      clr_pulse();

      // 5 timeout retry with in_nmi low
      bus.in_nmi = 1'b0;
      trap(2'd2, 1'b0, 8'h77);
      wait_rise("t5_rise");
      for (int r = 0; r < 2; r++) begin
         hi_width(n);
         chk("t5_width", 32'(n), 32'd8);
         lo_gap(n);
         chk("t5_gap", 32'(n), 32'd256);
      end
      bus.in_nmi = 1'b1;
      tick();
      pop_chk("t5_head");
      clr_pulse();
      chk("t5_idle", 32'(dut.state), 32'(IDLE));

      // 6 requeue: two traps, abort in REQ, service one, second request follows
      trap(2'd0, 1'b1, 8'h61);
`ifdef TRDEMU_TRAP_TSTAMP_EN
      ts1 = bus.cap_ts;
      for (int i = 0; i < 300; i++) tick();
`endif
      trap(2'd1, 1'b1, 8'h62);
      bus.in_nmi = 1'b0;
      wait_rise("t6_rise1");
      tick();
      bus.in_nmi = 1'b1;
      tick();
      chk("t6_abort", 32'(bus.nmi_req), 32'd0);
      chk("t6_service", 32'(dut.state), 32'(SERVICE));
      pop_chk("t6_head1");
      clr_pulse();
      tick();
      chk("t6_idle_hold", 32'({dut.state, bus.nmi_req}), 32'({IDLE, 1'b0}));
      bus.in_nmi = 1'b0;
      wait_rise("t6_rise2");
      hi_width(n);
      chk("t6_width2", 32'(n), 32'd8);
`ifdef TRDEMU_TRAP_TSTAMP_EN
      chk("t6_ts_inc", 32'(bus.cap_ts > ts1), 32'd1);
`endif
      bus.in_nmi = 1'b1;
      tick();
      pop_chk("t6_head2");
      clr_pulse();
      bus.in_nmi = 1'b0;

      // async reset in the middle of a request
      trap(2'd3, 1'b0, 8'h99);
      wait_rise("ar_rise");
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_nmi", 32'(bus.nmi_req), 32'd0);
      chk("ar_fifo", 32'({bus.cap_valid, bus.cap_level}), 32'd0);
      q.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("ar_discard", 32'({bus.cap_valid, bus.nmi_req}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
